// File: rtl/uart_pkg.sv
// Shared UART package: receive/transmit state types, frame constants and a
// majority-vote helper used by the optional receive-side glitch filter.
package uart_pkg;

    localparam int unsigned OVERSAMPLE = 16;
    localparam int unsigned MID_START  = 7;
    localparam int unsigned DATA_BITS  = 8;

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        STOP,
        WAIT_IDLE
    } rx_state_t;

    typedef enum logic [2:0] {
        TX_IDLE,
        TX_START,
        TX_DATA,
        TX_STOP
    } tx_state_t;

    // 2-of-3 majority
    function automatic logic maj3(input logic a, input logic b, input logic c);
        return (a & b) | (a & c) | (b & c);
    endfunction

endpackage

// File: rtl/uart_rx_if.sv
// Host-side register interface of the UART receiver.
//   i_read      pop one byte from the receive FIFO
//   i_clear_err clear the sticky error flags
//   o_data      FIFO head byte (valid when o_valid)
//   o_valid     FIFO not empty
//   o_active    receiver not idle
//   o_overrun   sticky: byte dropped, FIFO full
//   o_frame_err sticky: stop bit sampled low
// Modports: slave = receiver, master = host.
interface uart_rx_if;
    logic       i_read;
    logic       i_clear_err;
    logic [7:0] o_data;
    logic       o_valid;
    logic       o_active;
    logic       o_overrun;
    logic       o_frame_err;

    modport slave (
        input  i_read,
        input  i_clear_err,
        output o_data,
        output o_valid,
        output o_active,
        output o_overrun,
        output o_frame_err
    );

    modport master (
        output i_read,
        output i_clear_err,
        input  o_data,
        input  o_valid,
        input  o_active,
        input  o_overrun,
        input  o_frame_err
    );
endinterface

// File: rtl/fifo.sv
// Synchronous FIFO with registered head/valid outputs.
//   i_clk, i_reset_n  clock, async active-low reset (empties the FIFO)
//   i_push, i_wr_data write one entry; ignored when full
//   i_pop             advance the head; ignored when empty
//   o_head, o_valid   registered head entry and not-empty flag
//   o_full_c          combinational full flag
// DEPTH must be a power of two so the pointers wrap naturally.
module fifo #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned DEPTH = 8
) (
    input  logic             i_clk,
    input  logic             i_reset_n,
    input  logic             i_push,
    input  logic [WIDTH-1:0] i_wr_data,
    input  logic             i_pop,
    output logic [WIDTH-1:0] o_head,
    output logic             o_valid,
    output logic             o_full_c
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned CW = AW + 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic [AW-1:0]    rd_next_c;
    logic [CW-1:0]    count;
    logic [CW-1:0]    count_next_c;
    logic             do_push_c;
    logic             do_pop_c;
    logic [WIDTH-1:0] head_next_c;

    assign o_full_c     = (count == CW'(DEPTH));
    assign do_push_c    = i_push && !o_full_c;
    assign do_pop_c     = i_pop && (count != '0);
    assign rd_next_c    = rd_ptr + AW'(do_pop_c);
    assign count_next_c = count + CW'(do_push_c) - CW'(do_pop_c);
    // A byte written into the slot that becomes the head bypasses the array.
    assign head_next_c  = (do_push_c && (wr_ptr == rd_next_c)) ? i_wr_data : mem[rd_next_c];

    // Storage array, no reset
    always_ff @(posedge i_clk) begin
        if (do_push_c) begin
            mem[wr_ptr] <= i_wr_data;
        end
    end

    // Pointers, occupancy and registered head
    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            count   <= '0;
            o_head  <= '0;
            o_valid <= 1'b0;
        end else begin
            if (do_push_c) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            rd_ptr  <= rd_next_c;
            count   <= count_next_c;
            o_head  <= head_next_c;
            o_valid <= (count_next_c != '0);
        end
    end

endmodule

// File: rtl/uart_rx.sv
// UART receiver, 8N1, 16x oversampling, bytes buffered in a receive FIFO.
// Baud = clk / (16 * (i_baud_div + 1)), same divisor meaning as the TX side.
//   i_clk, i_reset_n  clock, async active-low reset
//   i_enable          receiver enable; low forces IDLE (FIFO/flags kept)
//   i_baud_div        oversample tick every i_baud_div+1 cycles
//   i_rx              asynchronous serial input, idle high
//   bus               host register interface (uart_rx_if.slave)
// Optional build macro UART_RX_MAJORITY_VOTE_EN: sample is the 2-of-3
// majority of the synchronized line over the last three ticks.
module uart_rx
    import uart_pkg::*;
#(
    parameter int unsigned FIFO_DEPTH = 8
) (
    input  logic        i_clk,
    input  logic        i_reset_n,
    input  logic        i_enable,
    input  logic [15:0] i_baud_div,
    input  logic        i_rx,
    uart_rx_if.slave    bus
);

    logic        rx_meta;
    logic        rxs;
    logic [15:0] baud_cnt;
    logic        tick_c;
    logic        sample_c;
    rx_state_t   state;
    logic [3:0]  sample_count;
    logic [2:0]  bit_count;
    logic [7:0]  shift_reg;
    logic        push_q;
    logic        active_q;
    logic        overrun_q;
    logic        frame_err_q;
    logic        fifo_full_c;

    // Two-flop synchronizer, idles high
    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            rx_meta <= 1'b1;
            rxs     <= 1'b1;
        end else begin
            rx_meta <= i_rx;
            rxs     <= rx_meta;
        end
    end

    // Free-running oversample tick; >= so a lowered divisor wraps at once
    assign tick_c = (baud_cnt >= i_baud_div);

    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            baud_cnt <= '0;
        end else begin
            baud_cnt <= tick_c ? 16'd0 : baud_cnt + 16'd1;
        end
    end

`ifdef UART_RX_MAJORITY_VOTE_EN
    // Two previous tick samples plus the current one form the 3-deep window
    logic [1:0] hist;

    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            hist <= 2'b11;
        end else if (tick_c) begin
            hist <= {hist[0], rxs};
        end
    end

    assign sample_c = maj3(hist[1], hist[0], rxs);
`else
    assign sample_c = rxs;
`endif

    // Receive state machine, error flags and FIFO push request
    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            state        <= IDLE;
            sample_count <= '0;
            bit_count    <= '0;
            shift_reg    <= '0;
            push_q       <= 1'b0;
            active_q     <= 1'b0;
            overrun_q    <= 1'b0;
            frame_err_q  <= 1'b0;
        end else begin
            push_q <= 1'b0;

            // Clear first so any set below in the same cycle wins
            if (bus.i_clear_err) begin
                overrun_q   <= 1'b0;
                frame_err_q <= 1'b0;
            end
            // Full is judged in the push cycle; a same-cycle read does not help
            if (push_q && fifo_full_c) begin
                overrun_q <= 1'b1;
            end

            if (!i_enable) begin
                state        <= IDLE;
                sample_count <= '0;
                active_q     <= 1'b0;
            end else if (tick_c) begin
                case (state)
                    IDLE: begin
                        if (!sample_c) begin
                            state        <= START;
                            sample_count <= '0;
                            active_q     <= 1'b1;
                        end
                    end
                    START: begin
                        if (sample_count == 4'(MID_START)) begin
                            sample_count <= '0;
                            if (!sample_c) begin
                                state     <= DATA;
                                bit_count <= '0;
                            end else begin
                                state    <= IDLE;
                                active_q <= 1'b0;
                            end
                        end else begin
                            sample_count <= sample_count + 4'd1;
                        end
                    end
                    DATA: begin
                        sample_count <= sample_count + 4'd1;
                        if (sample_count == 4'(OVERSAMPLE - 1)) begin
                            shift_reg <= {sample_c, shift_reg[7:1]};
                            if (bit_count == 3'(DATA_BITS - 1)) begin
                                state <= STOP;
                            end else begin
                                bit_count <= bit_count + 3'd1;
                            end
                        end
                    end
                    STOP: begin
                        sample_count <= sample_count + 4'd1;
                        if (sample_count == 4'(OVERSAMPLE - 1)) begin
                            if (sample_c) begin
                                push_q   <= 1'b1;
                                state    <= IDLE;
                                active_q <= 1'b0;
                            end else begin
                                frame_err_q <= 1'b1;
                                state       <= WAIT_IDLE;
                            end
                        end
                    end
                    WAIT_IDLE: begin
                        // Break holds here so it reports a single frame error
                        if (sample_c) begin
                            state    <= IDLE;
                            active_q <= 1'b0;
                        end
                    end
                    default: begin
                        state        <= IDLE;
                        sample_count <= '0;
                        active_q     <= 1'b0;
                    end
                endcase
            end
        end
    end

    fifo #(
        .WIDTH (8),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .i_clk     (i_clk),
        .i_reset_n (i_reset_n),
        .i_push    (push_q),
        .i_wr_data (shift_reg),
        .i_pop     (bus.i_read),
        .o_head    (bus.o_data),
        .o_valid   (bus.o_valid),
        .o_full_c  (fifo_full_c)
    );

    assign bus.o_active    = active_q;
    assign bus.o_overrun   = overrun_q;
    assign bus.o_frame_err = frame_err_q;

endmodule

// File: doc/uart_rx.md
# uart_rx

UART receiver, 8N1, with 16x oversampling and an output FIFO; the receive-side counterpart of the UART transmitter. It consumes the serial line driven by a remote transmitter, or by our own transmitter in loopback. It recovers bytes LSB-first and buffers them for the bus peripheral register interface. Baud rate = sysclk / (16 * (i_baud_div + 1)), identical formula and divisor meaning as the TX side, so one divisor register drives both.

## Interface
- FIFO_DEPTH, 8: receive FIFO depth in bytes (power of two, >= 2)
- i_clk  in  1  system clock
- i_reset_n  in  1  asynchronous active-low reset
- i_enable  in  1  receiver enable; low forces IDLE
- i_baud_div  in  16  oversample tick divisor; tick every i_baud_div+1 cycles
- i_rx  in  1  asynchronous serial input, idle high
- i_read  in  1  pop one byte from FIFO; ignored when empty
- i_clear_err  in  1  clears o_overrun and o_frame_err
- o_data  out  8  FIFO head byte; valid when o_valid
- o_valid  out  1  FIFO not empty
- o_active  out  1  state != IDLE
- o_overrun  out  1  sticky: byte dropped because FIFO full
- o_frame_err  out  1  sticky: stop bit sampled low

## Operation
- Reset values: all outputs 0, o_data 0x00. Synchronizer flops reset to 1; counters 0; state IDLE.
- i_rx passes through a 2-FF synchronizer; all logic uses the synchronized value `rxs`.
- Baud counter: 16-bit, counts 0..i_baud_div, then wraps to 0 and pulses `tick` for 1 cycle. Compare is >=, so lowering the divisor mid-count wraps on the next cycle. Runs regardless of i_enable.
- `sample_count` is 4 bits and advances only on tick.
- States:
  - IDLE: on tick with sample low, go to START with sample_count=0.
  - START: on the tick where sample_count==7 (mid start bit):
    - sample low: sample_count=0, bit_count=0, go to DATA.
    - sample high (glitch): return to IDLE; nothing pushed.
  - DATA: on every tick with sample_count==15 (mid-bit): shift_reg <= {sample, shift_reg[7:1]}. After the 8th bit, go to STOP.
  - STOP: at sample_count==15:
    - sample high: push shift_reg if FIFO not full, else set o_overrun and drop the byte. Go to IDLE.
    - sample low: set o_frame_err, discard the byte, go to WAIT_IDLE.
  - WAIT_IDLE: stay until a tick sees sample high, then go to IDLE. A break condition therefore yields exactly one frame error.
- Full check uses the FIFO full flag in the push cycle; an i_read in the same cycle does not prevent overrun.
- Sticky flags: i_clear_err clears them. If a set and a clear occur in the same cycle, set wins.
- i_enable low: state returns to IDLE, sample_count=0, no push. FIFO contents and sticky flags are retained; i_read still works.
- i_read and push in the same cycle on a non-full FIFO: both take effect.

## Timing
- Synchronizer latency: 2 cycles from i_rx to rxs.
- Start detection is effective within 1 tick of the falling edge.
- The byte is written to the FIFO 1 cycle after the stop-sample clock edge. o_valid and o_data update the cycle after the write.
- o_data is the FIFO head. i_read advances it on the next edge.
- Reset mid-frame: asynchronous return to IDLE and FIFO emptied. A partially received byte is lost and no flag is set.

## Configuration
- UART_RX_MAJORITY_VOTE_EN defined:
  - A 3-bit history of rxs is shifted on every tick.
  - sample = majority of the 3 values; for the START check, the majority of the last three ticks.
  - A single-tick glitch is rejected.
- Undefined: sample = rxs at the tick and the history register is absent.
- Bit timing and sample positions are identical in both builds.

## Structure
- Shared package uart_pkg holds:
  - rx_state_t: IDLE, START, DATA, STOP, WAIT_IDLE; 3-bit logic.
  - Constants: OVERSAMPLE=16, MID_START=7, DATA_BITS=8.
- The existing TX state typedef migrates into uart_pkg.
- Sub-module: reuse the existing fifo (WIDTH=8, DEPTH=FIFO_DEPTH) for the receive buffer; no new sub-modules.

## Test plan
- i_baud_div=0 (16 cycles/bit), send 0xA5 8N1 → o_valid rises, o_data=0xA5, no flags; i_read → o_valid low.
- Loopback from the transmitter, i_baud_div=3, bytes 0x00,0xFF,0x55 back-to-back → received in order, no flags.
- i_rx low for 4 ticks then high → START aborts to IDLE, o_valid stays 0, o_active returns 0.
- 0x3C with stop bit low, then line held low 40 ticks → o_frame_err=1 once, no byte pushed. Next 0x12 is received after line returns high. i_clear_err clears the flag.
- 9 bytes (0x01..0x09) with no reads, FIFO_DEPTH=8 → FIFO holds 0x01..0x08, o_overrun=1, 0x09 dropped.
- With UART_RX_MAJORITY_VOTE_EN: 1-tick high glitch mid-bit during 0x00 → 0x00 received. Without the macro, the glitch is sampled only if coincident with the sample tick. Assert i_reset_n mid-byte → all outputs return to reset values.
